period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures the clk-cycle interval between rising edges of a pulse/level input. This is the inverse of the periodic tick generator: ticks in, count out.
- Used downstream of the note-detection comparator to report the played-note period to the scoring logic.
- Averages 2^AVG_LOG2 consecutive periods per output, rejects glitch edges, and flags loss of signal.

Parameters:
- WIDTH, 27, width of cycle counter and period output.
- AVG_LOG2, 2, log2 of samples averaged per output (0 = every period reported).
- MIN_PERIOD, 16, edges arriving fewer than this many cycles after the last accepted edge are ignored.
- MAX_PERIOD, 27'd100_000_000, cycles without an accepted edge before timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  measurement enable; low forces IDLE
- sig_in  in  1  asynchronous input level; rising edges are measured
- period  out  WIDTH  averaged period in clk cycles, registered
- period_valid  out  1  one-cycle strobe; period updated this cycle
- locked  out  1  high once a period has been reported, until timeout/disable/reset
- timeout  out  1  one-cycle strobe on loss of signal

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset values: period=0, period_valid=0, locked=0, timeout=0. State is IDLE; synchronizer, counter, accumulator and sample count are cleared.
- Input path: 2-flop synchronizer, then a prev register. edge = sync2 & ~prev. Latency is a constant 3 cycles, so measured periods equal the input periods exactly.
- States: IDLE, RUN.
- IDLE:
  - cnt=0.
  - On edge: cnt<=1, go to RUN. No sample is taken.
- RUN: cnt increments each cycle and saturates at MAX_PERIOD.
- RUN, edge with cnt < MIN_PERIOD: edge ignored, cnt keeps counting.
- RUN, edge with cnt >= MIN_PERIOD:
  - sample = cnt; cnt<=1.
  - acc <= acc + sample. acc is WIDTH+AVG_LOG2 bits and cannot overflow.
  - nsamp <= nsamp + 1.
- Batch complete: on the sample that makes nsamp = 2^AVG_LOG2:
  - Next cycle: period <= (acc+sample) >> AVG_LOG2 (truncating), period_valid=1, locked=1.
  - acc and nsamp are cleared. Batches are blocks, not a sliding window.
- Timeout: RUN with cnt == MAX_PERIOD and no edge that cycle:
  - Next cycle: timeout=1, locked=0, period=0.
  - Go to IDLE; acc and nsamp cleared.
- Edge coincident with cnt == MAX_PERIOD: the edge wins and is accepted with sample = MAX_PERIOD. No timeout.
- enable low: go to IDLE next cycle and clear cnt/acc/nsamp/locked. period holds its value; no strobes. Synchronizer keeps running.
- Reset mid-batch: partial batch discarded; all outputs return to reset values the following cycle.
- period_valid and timeout never assert in the same cycle.

Decomposition:
- Shared package recorder_pkg holds:
  - CNT_WIDTH=27
  - CLK_HZ
  - state encoding (IDLE=1'b0, RUN=1'b1)
  - default MIN/MAX_PERIOD constants
- One sub-module, edge_sync: 2-flop synchronizer plus rising-edge detector. Ports clk, reset, d, edge.

Test Plan (WIDTH=27, AVG_LOG2=2, MIN_PERIOD=16, MAX_PERIOD=1000):
- Square wave, period 100 (50 high/50 low) -> first period_valid 1 cycle after the 5th edge strobe, period=100, locked=1; later strobes every 400 cycles, each period=100.
- Rising edges spaced 100,101,102,103 -> period = 406>>2 = 101.
- Period-100 wave plus a 2-cycle glitch pulse rising 8 cycles after an accepted edge -> glitch ignored, period=100, strobe timing unchanged.
- Locked on period 100, then sig_in held low -> timeout strobe 1000 cycles after the last accepted edge (+1 registered); period=0, locked=0. Input restarts -> the first edge takes no sample, and the 5th edge yields a valid.
- reset pulsed after 2 samples of a batch -> outputs 0 next cycle; resumed input needs 5 fresh edges before period_valid.
- enable dropped mid-batch for 10 cycles -> locked=0, period holds, no strobes; after re-enable, a valid appears only after 5 new edges.

Source files
------------

// File: rtl/recorder_pkg.sv
// Shared constants and types for the recorder measurement blocks.
//   CNT_WIDTH      : default cycle-counter width
//   CLK_HZ         : system clock frequency
//   DEF_MIN_PERIOD : default glitch-rejection threshold (cycles)
//   DEF_MAX_PERIOD : default loss-of-signal threshold (cycles)
//   state_t        : period meter state encoding
package recorder_pkg;

  localparam int unsigned CNT_WIDTH      = 27;
  localparam int unsigned CLK_HZ         = 100_000_000;
  localparam int unsigned DEF_MIN_PERIOD = 16;
  localparam int unsigned DEF_MAX_PERIOD = 100_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clk    : system clock
//   reset  : synchronous, active-high
//   d      : asynchronous input level
//   rise_c : high for one cycle after a synchronized rising edge
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise_c = sync2 & ~prev;

endmodule

// File: rtl/period_meter.sv
// Measures the clk-cycle interval between rising edges of sig_in, averages
// 2^AVG_LOG2 consecutive periods per report, ignores edges closer than
// MIN_PERIOD to the last accepted edge and flags loss of signal after
// MAX_PERIOD cycles without an accepted edge.
//   clk          : system clock
//   reset        : synchronous, active-high
//   enable       : measurement enable; low returns to IDLE
//   sig_in       : asynchronous input level
//   period       : averaged period in clk cycles (registered)
//   period_valid : one-cycle strobe when period updates
//   locked       : high once a period has been reported
//   timeout      : one-cycle strobe on loss of signal
module period_meter
  import recorder_pkg::*;
#(
  parameter int unsigned WIDTH      = CNT_WIDTH,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned ACC_W   = WIDTH + AVG_LOG2;
  localparam int unsigned NS_W    = AVG_LOG2 + 1;
  localparam int unsigned NS_LAST = (1 << AVG_LOG2) - 1;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [NS_W-1:0]  nsamp;

  logic             edge_c;
  logic             accept_c;
  logic             batch_done_c;
  logic             cnt_max_c;
  logic [ACC_W-1:0] sum_c;

  edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (sig_in),
    .rise_c (edge_c)
  );

  // An edge at exactly MAX_PERIOD is still accepted, so acceptance is
  // evaluated before the timeout condition.
  assign cnt_max_c    = (cnt == WIDTH'(MAX_PERIOD));
  assign accept_c     = (state == RUN) && edge_c && (cnt >= WIDTH'(MIN_PERIOD));
  assign batch_done_c = accept_c && (nsamp == NS_W'(NS_LAST));
  assign sum_c        = acc + ACC_W'(cnt);

  // Measurement FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      nsamp        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        acc    <= '0;
        nsamp  <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // First edge only starts the counter; no sample is taken.
            acc   <= '0;
            nsamp <= '0;
            if (edge_c) begin
              cnt   <= WIDTH'(1);
              state <= RUN;
            end else begin
              cnt <= '0;
            end
          end
          RUN: begin
            if (accept_c) begin
              cnt <= WIDTH'(1);
              if (batch_done_c) begin
                period       <= WIDTH'(sum_c >> AVG_LOG2);
                period_valid <= 1'b1;
                locked       <= 1'b1;
                acc          <= '0;
                nsamp        <= '0;
              end else begin
                acc   <= sum_c;
                nsamp <= nsamp + NS_W'(1);
              end
            end else if (cnt_max_c) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              period  <= '0;
              state   <= IDLE;
              cnt     <= '0;
              acc     <= '0;
              nsamp   <= '0;
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  localparam int unsigned WIDTH = 27;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  typedef struct {
    bit   is_to;
    int   per;
    bit   lck;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  period_meter #(
    .WIDTH      (27),
    .AVG_LOG2   (2),
    .MIN_PERIOD (16),
    .MAX_PERIOD (1000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rising edge now; the DUT reports it 3 cycles later.
  task automatic pulse(input int hi, input int lo, input bit expv, input int expp);
    exp_t e;
    sig_in = 1'b1;
    if (expv) begin
      e.is_to = 1'b0; e.per = expp; e.lck = 1'b1; e.cyc = cyc + 3;
      q.push_back(e);
    end
    repeat (hi) tick();
    sig_in = 1'b0;
    repeat (lo) tick();
  endtask

  // 100-cycle period with a 2-cycle glitch rising 8 cycles after the edge.
  task automatic glitch_pulse();
    sig_in = 1'b1; repeat (4) tick();
    sig_in = 1'b0; repeat (4) tick();
    sig_in = 1'b1; repeat (2) tick();
    sig_in = 1'b0; repeat (90) tick();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (period_valid || timeout)) begin
        n_chk++;
        if (period_valid && timeout) begin
          n_fail++;
          $display("FAIL strobe_overlap: valid=%0b timeout=%0b cycle %0d", period_valid, timeout, cyc);
        end
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: valid=%0b timeout=%0b period=%0d cycle %0d",
                   period_valid, timeout, period, cyc);
        end else begin
          e = q.pop_front();
          if (timeout != e.is_to || int'(period) != e.per || locked != e.lck || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL strobe: got to=%0b period=%0d locked=%0b cycle=%0d expected to=%0b period=%0d locked=%0b cycle=%0d",
                     timeout, period, locked, cyc, e.is_to, e.per, e.lck, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    exp_t e;
    int   r;
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (5) tick();

    // Square wave, period 100: reports on edges 5 and 9.
    for (int i = 1; i <= 9; i++) pulse(50, 50, (i == 5) || (i == 9), 100);
    chk("locked_after_batch", int'(locked), 1);

    // Spacings 100,101,102,103 -> 406 >> 2 = 101.
    pulse(51, 50, 1'b0, 0);
    pulse(51, 51, 1'b0, 0);
    pulse(52, 51, 1'b0, 0);
    pulse(50, 50, 1'b1, 101);

    // Glitch inside one interval is ignored.
    glitch_pulse();
    pulse(50, 50, 1'b0, 0);
    pulse(50, 50, 1'b0, 0);

    // Last edge, then input held low -> timeout 1000 cycles later (+3 path).
    sig_in = 1'b1;
    r = cyc;
    e.is_to = 1'b0; e.per = 100; e.lck = 1'b1; e.cyc = r + 3;
    q.push_back(e);
    e.is_to = 1'b1; e.per = 0; e.lck = 1'b0; e.cyc = r + 1003;
    q.push_back(e);
    repeat (50) tick();
    sig_in = 1'b0;
    repeat (1100) tick();
    chk("to_locked", int'(locked), 0);
    chk("to_period", int'(period), 0);

    // Restart: first edge takes no sample, fifth edge reports.
    for (int i = 1; i <= 5; i++) pulse(50, 50, i == 5, 100);

    // Two samples into a batch, then reset.
    pulse(50, 50, 1'b0, 0);
    pulse(50, 20, 1'b0, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_valid", int'(period_valid), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    repeat (30) tick();
    for (int i = 1; i <= 5; i++) pulse(50, 50, i == 5, 100);

    // Two samples, then enable dropped for 10 cycles.
    pulse(50, 50, 1'b0, 0);
    pulse(50, 20, 1'b0, 0);
    enable = 1'b0;
    repeat (10) tick();
    chk("dis_locked", int'(locked), 0);
    chk("dis_period_hold", int'(period), 100);
    enable = 1'b1;
    repeat (30) tick();

    // Five fresh edges at period 120.
    for (int i = 1; i <= 4; i++) pulse(60, 60, 1'b0, 0);
    pulse(60, 940, 1'b1, 120);

    // Spacing exactly MAX_PERIOD: edge wins, no timeout.
    repeat (3) pulse(500, 500, 1'b0, 0);
    pulse(8, 8, 1'b1, 1000);

    // Spacing exactly MIN_PERIOD is accepted.
    repeat (3) pulse(8, 8, 1'b0, 0);
    pulse(8, 40, 1'b1, 16);

    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
